// File: rtl/iir_cfg_pkg.sv
// rtl/iir_cfg_pkg.sv - shared types and constants for the IIR coefficient loader
package iir_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_SAFE,
        COMMIT,
        VERIFY
    } ldr_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_VERIFY  = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_ABORT   = 2'b11
    } ldr_err_e;

    // Word order of a coefficient set on the stream and in the shadow bank
    localparam int B0_IDX = 0;
    localparam int B1_IDX = 1;
    localparam int B2_IDX = 2;
    localparam int A1_IDX = 3;
    localparam int A2_IDX = 4;

endpackage

// File: rtl/iir_gap_detect.sv
// rtl/iir_gap_detect.sv - idle-gap and timeout counters for the commit window
module iir_gap_detect #(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic filt_valid_in,
    output logic gap_ok,
    output logic timed_out
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [GAP_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    // Both counters saturate so a long wait can never alias back to a commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
            tmo_cnt <= '0;
        end else if (clear) begin
            gap_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (filt_valid_in) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_MAX) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
            if (tmo_cnt != TMO_LAST) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    assign gap_ok    = !filt_valid_in && (gap_cnt == GAP_LAST);
    assign timed_out = (tmo_cnt == TMO_LAST);

endmodule

// File: rtl/iir_coeff_loader.sv
// rtl/iir_coeff_loader.sv - stages a biquad coefficient set and commits it in an idle gap
module iir_coeff_loader
    import iir_cfg_pkg::*;
#(
    parameter int COEFF_WIDTH = 20,
    parameter int COEFF_DEPTH = 5,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic                                    abort,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [COEFF_WIDTH-1:0]                  cfg_data,
    input  logic                                    filt_valid_in,
    output logic                                    coeff_wr_en,
    output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_in,
    input  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_out,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    error,
    output logic [1:0]                              err_code
);

    localparam int WC_W = $clog2(COEFF_DEPTH);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(COEFF_DEPTH - 1);

    ldr_state_e      state_q;
    ldr_state_e      state_d;
    logic [WC_W-1:0] word_cnt;
    logic            accept;
    logic            gap_ok;
    logic            timed_out;
    logic            done_d;
    logic            error_d;
    logic [1:0]      code_d;

    assign cfg_ready   = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign coeff_wr_en = (state_q == COMMIT);
    assign accept      = cfg_valid && cfg_ready;

    iir_gap_detect #(
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) u_gap_detect (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (state_q != WAIT_SAFE),
        .filt_valid_in (filt_valid_in),
        .gap_ok        (gap_ok),
        .timed_out     (timed_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            done     <= done_d;
            error    <= error_d;
            err_code <= code_d;
        end
    end

    // Abort outranks commit and timeout; COMMIT ignores it since the write is already out
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        code_d  = err_code;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    code_d  = ERR_ABORT;
                end else if (accept && (word_cnt == LAST_WORD)) begin
                    state_d = WAIT_SAFE;
                end
            end
            WAIT_SAFE: begin
                if (abort) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    code_d  = ERR_ABORT;
                end else if (gap_ok) begin
                    state_d = COMMIT;
                end else if (timed_out) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end
            end
            COMMIT: begin
                state_d = VERIFY;
            end
            VERIFY: begin
                state_d = IDLE;
                if (abort) begin
                    error_d = 1'b1;
                    code_d  = ERR_ABORT;
                end else if (coeff_out == coeff_in) begin
                    done_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                    code_d  = ERR_VERIFY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if ((state_q == IDLE) && start) begin
            word_cnt <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + WC_W'(1);
        end
    end

    // Shadow bank is never cleared on exit so coeff_in stays stable between sessions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coeff_in <= '0;
        end else if (accept) begin
            coeff_in[word_cnt] <= cfg_data;
        end
    end

endmodule
